// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2x2_stream
// Description : Streaming 2x2 / stride-2 signed max-pooling stage. Accepts one
//               activation per beat in raster order and emits one pooled value
//               per 2x2 window through a single-entry output register with
//               valid/ready handshakes on both sides.
// Options     : MAXPOOL_RELU_CLAMP_EN - clamp negative pooled maxima to zero
//               (debug safety net when the upstream ReLU is bypassed).
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2x2_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  frame_done
);

   localparam int COL_W    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int IDX_W    = (COL_W > 1) ? (COL_W - 1) : 1;
   // Depth rounded up to a power of two so the index spans the array exactly;
   // entries beyond IMG_WIDTH/2 are simply never addressed.
   localparam int LB_DEPTH = 1 << IDX_W;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0]             col;
   logic [ROW_W-1:0]             row;
   logic signed [DATA_WIDTH-1:0] pair_reg;
   logic signed [DATA_WIDTH-1:0] line_buf [LB_DEPTH];
   logic                         out_last;

   logic                         transfer;
   logic                         col_wrap;
   logic                         row_wrap;
   logic                         odd_col;
   logic                         odd_row;
   logic                         load_out;
   logic                         last_window;
   logic [IDX_W-1:0]             lb_idx;
   logic signed [DATA_WIDTH-1:0] in_s;
   logic signed [DATA_WIDTH-1:0] lb_rd;
   logic signed [DATA_WIDTH-1:0] hmax;
   logic signed [DATA_WIDTH-1:0] vmax;
   logic signed [DATA_WIDTH-1:0] pooled;

   // Output register is single-entry: space exists when empty or draining.
   assign in_ready = !out_valid || out_ready;
   assign transfer = in_valid && in_ready;

   assign col_wrap    = (col == COL_LAST);
   assign row_wrap    = (row == ROW_LAST);
   assign odd_col     = col[0];
   assign odd_row     = row[0];
   assign load_out    = transfer && odd_col && odd_row;
   assign last_window = col_wrap && row_wrap;

   // Line buffer holds one horizontal max per window column.
   generate
      if (COL_W > 1) begin : g_idx_wide
         assign lb_idx = col[COL_W-1:1];
      end else begin : g_idx_narrow
         assign lb_idx = 1'b0;
      end
   endgenerate

   assign in_s  = $signed(in_data);
   assign lb_rd = line_buf[lb_idx];

   // Signed horizontal and vertical maxima; ties may keep either operand.
   always_comb begin
      hmax = (in_s > pair_reg) ? in_s : pair_reg;
      vmax = (lb_rd > hmax) ? lb_rd : hmax;
`ifdef MAXPOOL_RELU_CLAMP_EN
      pooled = vmax[DATA_WIDTH-1] ? '0 : vmax;
`else
      pooled = vmax;
`endif
   end

   // Raster position counters advance only on accepted beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (transfer) begin
         if (col_wrap) begin
            col <= '0;
            row <= row_wrap ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Left pixel of each horizontal pair is parked until its partner arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_reg <= '0;
      end else if (transfer && !odd_col) begin
         pair_reg <= in_s;
      end
   end

   // Top-row horizontal maxima; always written before read within a plane.
   always_ff @(posedge clk) begin
      if (transfer && odd_col && !odd_row) begin
         line_buf[lb_idx] <= hmax;
      end
   end

   // Output register: a fresh window result takes priority over draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_data  <= pooled;
         out_last  <= last_window;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Pulse once after the last pooled value of a plane leaves the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_valid && out_ready && out_last;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool2x2_stream
// Description : Directed self-checking bench for maxpool2x2_stream using a
//               4x4 instance and a 2x2 instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool2x2_stream;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, frame_done4;
   logic [15:0] in_data4, out_data4;
   logic        in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
   logic [15:0] in_data2, out_data2;

   logic [15:0] got_q [$];
   int          got_cyc_q [$];
   int          fd_cyc_q [$];
   logic [15:0] stim [$];
   int          pix_cyc [64];

   always #5 clk = ~clk;

   // Free-running cycle index used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .frame_done(frame_done4)
   );

   maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .frame_done(frame_done2)
   );

   task automatic clear_logs();
      got_q.delete();
      got_cyc_q.delete();
      fd_cyc_q.delete();
      stim.delete();
   endtask

   task automatic step4(input logic v, input logic [15:0] d, input logic ordy,
                        output logic took, output logic rdy, output int c);
      in_valid4 = v; in_data4 = d; out_ready4 = ordy;
      #1;
      c    = cyc;
      rdy  = in_ready4;
      took = v && in_ready4;
      if (out_valid4 && ordy) begin
         got_q.push_back(out_data4);
         got_cyc_q.push_back(cyc);
      end
      if (frame_done4) fd_cyc_q.push_back(cyc);
      @(posedge clk); #1;
   endtask

   task automatic step2(input logic v, input logic [15:0] d, input logic ordy,
                        output logic took);
      in_valid2 = v; in_data2 = d; out_ready2 = ordy;
      #1;
      took = v && in_ready2;
      if (out_valid2 && ordy) begin
         got_q.push_back(out_data2);
         got_cyc_q.push_back(cyc);
      end
      if (frame_done2) fd_cyc_q.push_back(cyc);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      in_valid4 = 0; in_data4 = 0; out_ready4 = 1;
      in_valid2 = 0; in_data2 = 0; out_ready2 = 1;
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      clear_logs();
   endtask

   // Streams stim[] into the 4x4 instance with out_ready held high, then drains.
   task automatic feed4(input bit gaps);
      int idx = 0;
      int guard = 0;
      logic v, took, rdy;
      int c;
      while (idx < stim.size() && guard < 400) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         step4(v, stim[idx], 1'b1, took, rdy, c);
         if (took) begin
            pix_cyc[idx] = c;
            idx++;
         end
         guard++;
      end
      checks++;
      if (idx != stim.size()) begin
         failures++;
         $display("FAIL feed4_timeout: sent %0d beats, required %0d", idx, stim.size());
      end
      repeat (4) step4(1'b0, 16'd0, 1'b1, took, rdy, c);
   endtask

   task automatic feed2();
      logic took;
      int idx = 0;
      int guard = 0;
      while (idx < stim.size() && guard < 50) begin
         step2(1'b1, stim[idx], 1'b1, took);
         if (took) idx++;
         guard++;
      end
      checks++;
      if (idx != stim.size()) begin
         failures++;
         $display("FAIL feed2_timeout: sent %0d beats, required %0d", idx, stim.size());
      end
      repeat (4) step2(1'b0, 16'd0, 1'b1, took);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (out_valid4 !== 1'b0) begin failures++; $display("FAIL rst_out_valid4: got %b need 0", out_valid4); end
      if (out_data4 !== 16'h0) begin failures++; $display("FAIL rst_out_data4: got %h need 0000", out_data4); end
      if (frame_done4 !== 1'b0) begin failures++; $display("FAIL rst_frame_done4: got %b need 0", frame_done4); end
      if (in_ready4 !== 1'b1) begin failures++; $display("FAIL rst_in_ready4: got %b need 1", in_ready4); end
      if (out_valid2 !== 1'b0) begin failures++; $display("FAIL rst_out_valid2: got %b need 0", out_valid2); end
      if (out_data2 !== 16'h0) begin failures++; $display("FAIL rst_out_data2: got %h need 0000", out_data2); end
   endtask

   task automatic test_basic();
      logic [15:0] exp_v [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
      int          win_px [4] = '{5, 7, 13, 15};
      do_reset();
      for (int p = 0; p < 16; p++) stim.push_back(16'(p));
      feed4(1'b0);
      checks++;
      if (got_q.size() != 4) begin failures++; $display("FAIL basic_count: got %0d need 4", got_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (i >= got_q.size()) begin
            failures += 2;
            $display("FAIL basic_out%0d: missing, need %0d", i, exp_v[i]);
         end else begin
            if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL basic_out%0d: got %0d need %0d", i, got_q[i], exp_v[i]); end
            if (got_cyc_q[i] != pix_cyc[win_px[i]] + 1) begin
               failures++;
               $display("FAIL basic_lat%0d: got cycle %0d need %0d", i, got_cyc_q[i], pix_cyc[win_px[i]] + 1);
            end
         end
      end
      checks++;
      if (fd_cyc_q.size() != 1) begin
         failures++; $display("FAIL basic_fd_count: got %0d need 1", fd_cyc_q.size());
      end else if (got_q.size() == 4) begin
         checks++;
         if (fd_cyc_q[0] != got_cyc_q[3] + 1) begin
            failures++; $display("FAIL basic_fd_cycle: got %0d need %0d", fd_cyc_q[0], got_cyc_q[3] + 1);
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] exp_v [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
      int   p = 0;
      int   stall_left = 0;
      bit   seen = 0;
      logic ordy, took, rdy;
      int   c;
      do_reset();
      for (int k = 0; k < 30; k++) begin
         if (!seen && out_valid4) begin seen = 1; stall_left = 3; end
         ordy = (stall_left == 0);
         step4(p < 16, 16'(p), ordy, took, rdy, c);
         if (took) p++;
         if (stall_left > 0) begin
            checks += 2;
            if (rdy !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b need 0", rdy); end
            if (out_data4 !== 16'd5) begin failures++; $display("FAIL stall_hold: got %0d need 5", out_data4); end
            stall_left--;
         end
      end
      checks += 3;
      if (p != 16) begin failures++; $display("FAIL stall_beats: got %0d need 16", p); end
      if (got_q.size() != 4) begin failures++; $display("FAIL stall_count: got %0d need 4", got_q.size()); end
      if (fd_cyc_q.size() != 1) begin failures++; $display("FAIL stall_fd_count: got %0d need 1", fd_cyc_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL stall_out%0d: got %0d need %0d", i, got_q[i], exp_v[i]); end
      end
   endtask

   task automatic test_negative();
      logic [15:0] expv;
`ifdef MAXPOOL_RELU_CLAMP_EN
      expv = 16'h0000;
`else
      expv = 16'hFFFF;
`endif
      do_reset();
      stim.push_back(16'hFFFD); stim.push_back(16'hFFF9);
      stim.push_back(16'hFFFF); stim.push_back(16'hFFF7);
      feed2();
      checks += 2;
      if (got_q.size() != 1) begin
         failures++; $display("FAIL neg_count: got %0d need 1", got_q.size());
      end else if (got_q[0] !== expv) begin
         failures++; $display("FAIL neg_value: got %h need %h", got_q[0], expv);
      end
      if (fd_cyc_q.size() != 1) begin failures++; $display("FAIL neg_fd_count: got %0d need 1", fd_cyc_q.size()); end
   endtask

   task automatic test_extremes();
      do_reset();
      stim.push_back(16'h8000); stim.push_back(16'h7FFF);
      stim.push_back(16'h0000); stim.push_back(16'hFFFF);
      feed2();
      checks++;
      if (got_q.size() != 1) begin
         failures++; $display("FAIL ext_count: got %0d need 1", got_q.size());
      end else if (got_q[0] !== 16'h7FFF) begin
         failures++; $display("FAIL ext_value: got %h need 7fff", got_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp_v [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
      logic took, rdy;
      int   c;
      do_reset();
      for (int p = 0; p < 6; p++) step4(1'b1, 16'(p), 1'b0, took, rdy, c);
      checks++;
      if (out_valid4 !== 1'b1) begin failures++; $display("FAIL mid_pending: got %b need 1", out_valid4); end
      rst = 1'b1;
      step4(1'b0, 16'd0, 1'b0, took, rdy, c);
      rst = 1'b0;
      checks += 2;
      if (out_valid4 !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b need 0", out_valid4); end
      if (out_data4 !== 16'h0) begin failures++; $display("FAIL mid_out_data: got %h need 0000", out_data4); end
      clear_logs();
      for (int p = 0; p < 16; p++) stim.push_back(16'(p));
      feed4(1'b0);
      checks += 2;
      if (got_q.size() != 4) begin failures++; $display("FAIL mid_count: got %0d need 4", got_q.size()); end
      if (fd_cyc_q.size() != 1) begin failures++; $display("FAIL mid_fd_count: got %0d need 1", fd_cyc_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL mid_out%0d: got %0d need %0d", i, got_q[i], exp_v[i]); end
      end
   endtask

   task automatic test_back_to_back();
      // Plane 0 ascends 0..15, plane 1 descends 31..16.
      logic [15:0] exp_v [8] = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd31, 16'd29, 16'd23, 16'd21};
      int          win_px [8] = '{5, 7, 13, 15, 21, 23, 29, 31};
      do_reset();
      for (int p = 0; p < 16; p++) stim.push_back(16'(p));
      for (int p = 0; p < 16; p++) stim.push_back(16'(31 - p));
      feed4(1'b1);
      checks += 2;
      if (got_q.size() != 8) begin failures++; $display("FAIL b2b_count: got %0d need 8", got_q.size()); end
      if (fd_cyc_q.size() != 2) begin failures++; $display("FAIL b2b_fd_count: got %0d need 2", fd_cyc_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         checks += 2;
         if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL b2b_out%0d: got %0d need %0d", i, got_q[i], exp_v[i]); end
         if (got_cyc_q[i] != pix_cyc[win_px[i]] + 1) begin
            failures++;
            $display("FAIL b2b_lat%0d: got cycle %0d need %0d", i, got_cyc_q[i], pix_cyc[win_px[i]] + 1);
         end
      end
      if (fd_cyc_q.size() == 2 && got_q.size() == 8) begin
         checks += 2;
         if (fd_cyc_q[0] != got_cyc_q[3] + 1) begin failures++; $display("FAIL b2b_fd0: got %0d need %0d", fd_cyc_q[0], got_cyc_q[3] + 1); end
         if (fd_cyc_q[1] != got_cyc_q[7] + 1) begin failures++; $display("FAIL b2b_fd1: got %0d need %0d", fd_cyc_q[1], got_cyc_q[7] + 1); end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid4 = 0; in_data4 = 0; out_ready4 = 1;
      in_valid2 = 0; in_data2 = 0; out_ready2 = 1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_stall();
      test_negative();
      test_extremes();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
